// File: rtl/adder_chk_pkg.sv
// Shared types and helpers for the adder result checker.
// Holds the FSM state encoding, default geometry and the reference sum.
package adder_chk_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_LATENCY = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } chk_state_e;

    // Full-width sum; callers truncate to their operand width to drop the carry.
    function automatic logic [63:0] exp_sum(input logic [63:0] a, input logic [63:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/chk_delay_line.sv
// Fixed-depth pipeline of {valid, data} used to align expected sums with DUT results.
// Valids are cleared by reset or clear; data simply shifts.
module chk_delay_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [DEPTH-1:0]  valid_q;
    logic [DATA_W-1:0] data_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
        end else begin
            if (clear) begin
                valid_q <= '0;
            end else begin
                valid_q[0] <= in_valid;
                for (int i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
            end
            data_q[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/adder_result_checker.sv
// Output-side checker for the 8-bit adder: compares io_X against latency-aligned
// expected sums, counts checks and mismatches, and captures the first failure.
//
//   state | meaning
//   IDLE  | waiting for the first valid transaction
//   RUN   | comparing every result leaving the delay line
//   HALT  | stopped after a mismatch (STOP_ON_ERR); counters and flags frozen
module adder_result_checker
    import adder_chk_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int LATENCY     = DEF_LATENCY,
    parameter int CNT_W       = 32,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] io_A,
    input  logic [WIDTH-1:0] io_B,
    input  logic [WIDTH-1:0] io_X,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_flag,
    output logic             halted,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_got,
    output logic [CNT_W-1:0] first_err_idx
);

    chk_state_e       state_q;
    chk_state_e       state_d;
    logic [WIDTH-1:0] exp_in;
    logic             dl_valid;
    logic [WIDTH-1:0] dl_exp;
    logic             do_cmp;
    logic             mismatch;

    assign exp_in = WIDTH'(exp_sum(64'(io_A), 64'(io_B)));

    chk_delay_line #(
        .DEPTH  (LATENCY),
        .DATA_W (WIDTH)
    ) u_delay (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (en),
        .in_data   (exp_in),
        .out_valid (dl_valid),
        .out_data  (dl_exp)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        do_cmp   = 1'b0;
        mismatch = 1'b0;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (en) state_d = RUN;
                RUN: begin
                    do_cmp   = dl_valid;
                    mismatch = dl_valid && (io_X != dl_exp);
                    if (mismatch && STOP_ON_ERR) state_d = HALT;
                end
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    assign halted = (state_q == HALT);

    // Counters saturate; first-error fields load only while err_flag is still low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            check_cnt     <= '0;
            err_cnt       <= '0;
            err_flag      <= 1'b0;
            first_err_exp <= '0;
            first_err_got <= '0;
            first_err_idx <= '0;
        end else if (clear) begin
            check_cnt     <= '0;
            err_cnt       <= '0;
            err_flag      <= 1'b0;
            first_err_exp <= '0;
            first_err_got <= '0;
            first_err_idx <= '0;
        end else if (do_cmp) begin
            if (check_cnt != '1) check_cnt <= check_cnt + CNT_W'(1);
            if (mismatch) begin
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                err_flag <= 1'b1;
                if (!err_flag) begin
                    first_err_exp <= dl_exp;
                    first_err_got <= io_X;
                    first_err_idx <= check_cnt;
                end
            end
        end
    end

endmodule

// File: doc/adder_result_checker.md
# adder_result_checker

Synthesizable result checker for the 8-bit adder top level (`MyTopLevel`), placed on the DUT's output side. It taps the stimulus applied to `io_A`/`io_B` and the DUT result `io_X`, and aligns expected sums through a latency-matched delay line. It compares every valid result, counts checks and mismatches, and latches the first failing transaction for post-run inspection by the bench or a debug bus.

## Interface
- `WIDTH`, 8: operand/result width.
- `LATENCY`, 1: DUT cycles from operand to result; legal range 1..8.
- `CNT_W`, 32: width of the check and error counters.
- `STOP_ON_ERR`, 0: when 1, checking halts after the first mismatch.

Ports:
- `clk` in 1: single clock; all state on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `clear` in 1: synchronous soft clear, same effect as reset.
- `en` in 1: operands on `io_A`/`io_B` this cycle are a valid transaction.
- `io_A` in WIDTH: operand A as driven to the DUT.
- `io_B` in WIDTH: operand B as driven to the DUT.
- `io_X` in WIDTH: DUT result.
- `check_cnt` out CNT_W: number of results compared.
- `err_cnt` out CNT_W: number of mismatches.
- `err_flag` out 1: sticky; set on the first mismatch.
- `halted` out 1: high in HALT.
- `first_err_exp` out WIDTH: expected value of the first mismatch.
- `first_err_got` out WIDTH: `io_X` value of the first mismatch.
- `first_err_idx` out CNT_W: `check_cnt` value at the first mismatch (0-based).

## Operation
- Expected value: `exp = (io_A + io_B) mod 2^WIDTH`. The carry is discarded, because the DUT result is WIDTH bits.
- Delay line: LATENCY stages of {valid, exp}. Stage 0 loads {`en`, exp} each cycle. Compare when the last-stage valid is 1.
- FSM:
  - IDLE → RUN on the first cycle with `en`=1.
  - RUN → HALT on a mismatch if `STOP_ON_ERR`=1.
  - Any state → IDLE on `clear`.
  - HALT is exited only by reset or clear.
  - Compares are performed in RUN only. In-flight transactions are still compared in RUN even if `en` has since dropped.
- On a compare: `check_cnt`+1. On a mismatch, additionally `err_cnt`+1 and `err_flag`←1.
- First-error fields load only when `err_flag` is 0, then hold.
- Both counters saturate at all-ones and never wrap.
- In HALT the delay line keeps shifting, but counters and flags freeze.
- Reset values: counters 0, `err_flag` 0, `halted` 0, all `first_err_*` 0, all delay-line valids 0, FSM IDLE.

## Timing
- A transaction sampled at edge t (with `en`=1) is compared against `io_X` at edge t+LATENCY.
- `check_cnt`/`err_cnt`/`err_flag` become visible one cycle after the compare edge (registered outputs).
- `halted` rises in the same cycle `err_flag` rises.
- No compares occur during the first LATENCY cycles after reset or clear, because the delay-line valids are 0. Garbage on `io_X` in that window is ignored.
- Back-to-back `en` is fully supported, one compare per cycle. `en` gaps produce no compare at the corresponding later cycle.
- `clear` coinciding with a compare: clear wins, and the compare is discarded.
- Asynchronous `reset` mid-run: in-flight transactions are dropped and never counted.
- Simultaneous saturation and mismatch: `err_flag` and the first-error capture still update normally.

## Structure
- Shared package `adder_chk_pkg`:
  - FSM state enum {IDLE, RUN, HALT}.
  - The expected-sum function.
  - Default WIDTH/LATENCY constants.
- Sub-module `chk_delay_line`: parameterised depth LATENCY, carrying {valid, data} with async reset of the valids. The checker instantiates it once.

## Test plan
- Pass, LATENCY=1: `en`=1 with A=3, B=4, DUT returns X=7 one cycle later. Required: `check_cnt`=1, `err_cnt`=0, `err_flag`=0.
- Wrap: A=199, B=199, X=142. Required: pass, since 398 mod 256 = 142.
- Injected error, STOP_ON_ERR=0: the 5th transaction (A=10, B=20) returns X=31. Required: `err_cnt`=1, `first_err_exp`=30, `first_err_got`=31, `first_err_idx`=4. Run 10 transactions with one error: `check_cnt`=10, `err_cnt`=1.
- Halt, STOP_ON_ERR=1: same injection. Required: `halted`=1 and `check_cnt` frozen at 5; a subsequent `clear` returns to IDLE with all outputs 0.
- Warm-up/latency, LATENCY=3: `io_X`=0xFF for 3 cycles after reset, then a correct stream. Required: `err_cnt`=0; the first compare occurs 3 cycles after the first `en`.
- Saturation/reset, CNT_W=4: 20 good transactions give `check_cnt`=15. Asserting `reset` mid-stream with 2 transactions in flight zeroes all outputs, and those transactions are never counted.
